// File: rtl/same_idx_gen.sv
// same_idx_gen: sequential same-mode convolution index generator.
// Walks the same-output index 0..len-1 and presents each index together with
// its full-convolution counterpart (index + offset) on a valid/ready stream.
// Every output is a flop; no input reaches an output combinationally.
module same_idx_gen #(
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             rst_a,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [IDX_W:0]   len_i,
   input  logic [IDX_W-1:0] offset_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] same_index_o,
   output logic [IDX_W:0]   full_index_o,
   output logic             last_o,
   output logic             busy_o,
   output logic             done_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Largest sweep the index width can express: 2**IDX_W indexes.
   localparam logic [IDX_W:0] LEN_MAX = {1'b1, {IDX_W{1'b0}}};

   state_t           state_reg;
   logic [IDX_W:0]   len_reg;
   logic [IDX_W-1:0] offset_reg;

   logic [IDX_W:0]   len_sat;
   logic [IDX_W-1:0] next_idx;
   logic [IDX_W:0]   next_full;
   logic             next_last;
   logic [IDX_W:0]   first_full;
   logic             first_last;

   // Next-value helpers: saturated length at start and the successor index in RUN.
   always_comb begin
      len_sat    = len_i[IDX_W] ? LEN_MAX : len_i;
      next_idx   = same_index_o + 1'b1;
      next_full  = {1'b0, next_idx} + {1'b0, offset_reg};
      next_last  = ({1'b0, next_idx} == (len_reg - 1'b1));
      first_full = {1'b0, offset_i};
      first_last = (len_sat == {{IDX_W{1'b0}}, 1'b1});
   end

   // Control FSM with registered outputs; abort has priority over everything but reset.
   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         state_reg    <= ST_IDLE;
         len_reg      <= '0;
         offset_reg   <= '0;
         valid_o      <= 1'b0;
         same_index_o <= '0;
         full_index_o <= '0;
         last_o       <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
      end else if (abort_i) begin
         state_reg    <= ST_IDLE;
         valid_o      <= 1'b0;
         same_index_o <= '0;
         full_index_o <= '0;
         last_o       <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
      end else begin
         unique case (state_reg)
            ST_IDLE: begin
               if (start_i) begin
                  len_reg    <= len_sat;
                  offset_reg <= offset_i;
                  busy_o     <= 1'b1;
                  if (len_sat != '0) begin
                     state_reg    <= ST_RUN;
                     valid_o      <= 1'b1;
                     same_index_o <= '0;
                     full_index_o <= first_full;
                     last_o       <= first_last;
                  end else begin
                     // Empty sweep: go straight to completion without emitting.
                     state_reg <= ST_DONE;
                     done_o    <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (valid_o && ready_i) begin
                  if (last_o) begin
                     state_reg    <= ST_DONE;
                     valid_o      <= 1'b0;
                     same_index_o <= '0;
                     full_index_o <= '0;
                     last_o       <= 1'b0;
                     done_o       <= 1'b1;
                  end else begin
                     same_index_o <= next_idx;
                     full_index_o <= next_full;
                     last_o       <= next_last;
                  end
               end
            end
            ST_DONE: begin
               state_reg <= ST_IDLE;
               done_o    <= 1'b0;
               busy_o    <= 1'b0;
            end
            default: begin
               state_reg <= ST_IDLE;
               valid_o   <= 1'b0;
               last_o    <= 1'b0;
               busy_o    <= 1'b0;
               done_o    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_same_idx_gen.sv
// tb_same_idx_gen: scoreboard bench for same_idx_gen (IDX_W = 5).
// Expected index triples are queued when a sweep is started and popped on
// every accepted transfer.
module tb_same_idx_gen;

   localparam int IDX_W = 5;

   logic             clk;
   logic             rst_a;
   logic             start_i;
   logic             abort_i;
   logic [IDX_W:0]   len_i;
   logic [IDX_W-1:0] offset_i;
   logic             ready_i;
   logic             valid_o;
   logic [IDX_W-1:0] same_index_o;
   logic [IDX_W:0]   full_index_o;
   logic             last_o;
   logic             busy_o;
   logic             done_o;

   same_idx_gen #(.IDX_W(IDX_W)) dut (
      .clk          (clk),
      .rst_a        (rst_a),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .len_i        (len_i),
      .offset_i     (offset_i),
      .ready_i      (ready_i),
      .valid_o      (valid_o),
      .same_index_o (same_index_o),
      .full_index_o (full_index_o),
      .last_o       (last_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected entry packing: {last, full[5:0], idx[4:0]}
   logic [11:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_cyc = -100;
   int done_cyc = -100;
   int done_cnt = 0;
   int xfer_cnt = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock: compare an accepted transfer against the scoreboard, then advance.
   task automatic step(input logic rdy);
      logic [11:0] e;
      ready_i = rdy;
      if (valid_o && rdy) begin
         if (exp_q.size() == 0) begin
            check("spurious_xfer", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("same_index", int'(same_index_o), int'(e[4:0]));
            check("full_index", int'(full_index_o), int'(e[10:5]));
            check("last", int'(last_o), int'(e[11]));
            $display("xfer cyc=%0d idx=%0d full=%0d last=%0b", cyc, same_index_o, full_index_o, last_o);
            xfer_cnt++;
            if (e[11]) last_cyc = cyc;
         end
      end
      if (done_o) begin
         done_cnt++;
         done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Accept a start and queue the expected sweep from an independent model.
   task automatic do_start(input int len, input int off);
      int n;
      logic [11:0] e;
      n = (len > 32) ? 32 : len;
      for (int i = 0; i < n; i++) begin
         e[4:0]  = 5'(i);
         e[10:5] = 6'(i + off);
         e[11]   = (i == n - 1);
         exp_q.push_back(e);
      end
      done_cnt = 0;
      xfer_cnt = 0;
      len_i    = 6'(len);
      offset_i = 5'(off);
      start_i  = 1'b1;
      step(1'b1);
      start_i  = 1'b0;
      check("first_valid", int'(valid_o), (n > 0) ? 1 : 0);
      check("busy_after_start", int'(busy_o), 1);
   endtask

   // Run until idle with a cycle budget; mode 0 = ready always, 1 = random ready.
   task automatic run_sweep(input int mode);
      int guard = 0;
      while (busy_o && guard < 400) begin
         step((mode == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
         guard++;
      end
      if (guard >= 400) check("timeout", 1, 0);
   endtask

   task automatic end_sweep_checks(input int n_exp);
      check("queue_empty", exp_q.size(), 0);
      check("xfer_count", xfer_cnt, n_exp);
      check("done_count", done_cnt, 1);
      check("busy_idle", int'(busy_o), 0);
   endtask

   initial begin
      int guard;
      rst_a    = 1'b0;
      start_i  = 1'b0;
      abort_i  = 1'b0;
      len_i    = '0;
      offset_i = '0;
      ready_i  = 1'b0;
      #12;
      check("rst_valid", int'(valid_o), 0);
      check("rst_busy", int'(busy_o), 0);
      check("rst_done", int'(done_o), 0);
      check("rst_idx", int'(same_index_o), 0);
      check("rst_full", int'(full_index_o), 0);
      check("rst_last", int'(last_o), 0);
      rst_a = 1'b1;
      @(posedge clk);
      #1;

      // 1: len=4 offset=2, ready high
      do_start(4, 2);
      run_sweep(0);
      end_sweep_checks(4);
      check("done_after_last", done_cyc, last_cyc + 1);

      // 2: same sweep with a three-cycle stall while index 1 is presented
      do_start(4, 2);
      step(1'b1);
      for (int i = 0; i < 3; i++) begin
         check("stall_valid", int'(valid_o), 1);
         check("stall_idx", int'(same_index_o), 1);
         step(1'b0);
      end
      run_sweep(0);
      end_sweep_checks(4);

      // 3: len=0 -> done pulse only, busy for a single cycle
      do_start(0, 7);
      check("len0_done", int'(done_o), 1);
      step(1'b1);
      check("len0_done_clr", int'(done_o), 0);
      check("len0_busy_clr", int'(busy_o), 0);
      check("len0_done_count", done_cnt, 1);

      // 4: len=40 saturates to 32, offset 31 -> last full index 62
      do_start(40, 31);
      run_sweep(1);
      end_sweep_checks(32);

      // 5: abort while index 2 is presented, then restart
      do_start(8, 0);
      guard = 0;
      while (!(valid_o && same_index_o == 5'd2) && guard < 20) begin
         step(1'b1);
         guard++;
      end
      check("abort_reach_idx2", int'(same_index_o), 2);
      abort_i = 1'b1;
      step(1'b0);
      abort_i = 1'b0;
      check("abort_valid", int'(valid_o), 0);
      check("abort_busy", int'(busy_o), 0);
      check("abort_idx", int'(same_index_o), 0);
      check("abort_full", int'(full_index_o), 0);
      check("abort_last", int'(last_o), 0);
      exp_q.delete();
      done_cnt = 0;
      for (int i = 0; i < 3; i++) step(1'b1);
      check("abort_no_done", done_cnt, 0);
      // abort together with start in IDLE: abort wins
      len_i   = 6'd3;
      start_i = 1'b1;
      abort_i = 1'b1;
      step(1'b1);
      start_i = 1'b0;
      abort_i = 1'b0;
      check("abort_vs_start_busy", int'(busy_o), 0);
      do_start(3, 5);
      run_sweep(0);
      end_sweep_checks(3);

      // 6: async reset mid-sweep, then a start pulse during RUN is ignored
      do_start(6, 1);
      step(1'b1);
      #3;
      rst_a = 1'b0;
      #1;
      check("arst_valid", int'(valid_o), 0);
      check("arst_busy", int'(busy_o), 0);
      check("arst_idx", int'(same_index_o), 0);
      check("arst_full", int'(full_index_o), 0);
      #2;
      rst_a = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      do_start(5, 3);
      step(1'b1);
      len_i   = 6'd2;
      offset_i = 5'd9;
      start_i = 1'b1;
      step(1'b1);
      start_i = 1'b0;
      run_sweep(0);
      end_sweep_checks(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
